// File: rtl/dither_ctrl_if.sv
// dither_ctrl_if: mode-change request handshake into the dither controller
interface dither_ctrl_if;
    logic       cfg_valid;
    logic [1:0] cfg_mode;
    logic       cfg_ready;
    modport master (output cfg_valid, cfg_mode, input cfg_ready);
    modport slave (input cfg_valid, cfg_mode, output cfg_ready);
endinterface

// File: rtl/dither_ctrl.sv
// dither_ctrl: frame-synchronous field/enable/frame-count generator with tear-free mode changes
module dither_ctrl #(
    parameter int FRAME_W     = 8,
    parameter int HOLD_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync_n,
    dither_ctrl_if.slave       cfg,
    output logic               dither_en,
    output logic               field,
    output logic [1:0]         mode,
    output logic [FRAME_W-1:0] frame_count,
    output logic               frame_tick
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t     state, state_nx;
    logic       vs_q, bnd, apply;
    logic [1:0] pend_mode;
    logic [7:0] hold;
    assign bnd = ~vs_q & vsync_n;
    assign cfg.cfg_ready = (state == IDLE);
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        apply    = 1'b0;
        state_nx = (state == IDLE) ? (cfg.cfg_valid ? PENDING : IDLE) : (bnd ? IDLE : PENDING);
        apply    = (state == PENDING) && bnd;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q        <= 1'b1;
            frame_tick  <= 1'b0;
            frame_count <= '0;
            mode        <= 2'd0;
            pend_mode   <= 2'd0;
            field       <= 1'b0;
            dither_en   <= 1'b0;
            hold        <= 8'd0;
        end else begin
            vs_q       <= vsync_n;
            frame_tick <= bnd;
            if (state == IDLE && cfg.cfg_valid)
                pend_mode <= cfg.cfg_mode;
            if (bnd) begin
                frame_count <= frame_count + 1'b1;
                if (apply) begin
                    mode      <= pend_mode;
                    hold      <= 8'd0;
                    field     <= 1'b0;
                    dither_en <= (pend_mode != 2'd0);
                end else begin
                    dither_en <= (mode != 2'd0);
                    // mode 3 holds each field phase for HOLD_FRAMES boundaries
                    if (mode == 2'd3) begin
                        hold  <= (hold == 8'(HOLD_FRAMES - 1)) ? 8'd0 : hold + 8'd1;
                        field <= (hold == 8'(HOLD_FRAMES - 1)) ? ~field : field;
                    end else begin
                        field <= (mode == 2'd2) ? ~field : 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dither_ctrl.sv
// tb_dither_ctrl: randomized scoreboard bench for dither_ctrl against a frame-level model
module tb_dither_ctrl;
    localparam int HOLD = 4;
    typedef struct {int mode; int field; int en; int fc;} exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync_n = 1'b1;
    logic       dither_en, field, frame_tick;
    logic [1:0] mode;
    logic [7:0] frame_count;
    dither_ctrl_if cif ();
    dither_ctrl #(.FRAME_W(8), .HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .reset(reset), .vsync_n(vsync_n), .cfg(cif.slave),
        .dither_en(dither_en), .field(field), .mode(mode),
        .frame_count(frame_count), .frame_tick(frame_tick)
    );
    always #5 clk = ~clk;
    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0, n_bad = 0;
    int   m_mode, m_pmode, m_since, m_fc, m_pend, m_prev, exp_ready;
    task automatic chk(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask
    function automatic int exp_field(input int md, input int since);
        return md == 2 ? since % 2 : md == 3 ? (since / HOLD) % 2 : 0;
    endfunction
    // frame-level model: evaluated once per clock edge using the inputs that edge sees
    task automatic model();
        int b, acc;
        if (reset) begin
            m_fc = 0; m_mode = 0; m_since = 0; m_pend = 0; m_prev = 1; exp_ready = 1;
            return;
        end
        b = (m_prev == 0 && vsync_n) ? 1 : 0;
        m_prev = int'(vsync_n);
        acc = (cif.cfg_valid && m_pend == 0) ? 1 : 0;
        if (b != 0) begin
            m_fc = (m_fc + 1) % 256;
            if (m_pend != 0) begin
                m_mode = m_pmode; m_since = 0; m_pend = 0;
            end else m_since++;
            q.push_back('{m_mode, exp_field(m_mode, m_since), m_mode != 0 ? 1 : 0, m_fc});
        end
        if (acc != 0) begin
            m_pend = 1; m_pmode = int'(cif.cfg_mode);
        end
        exp_ready = m_pend == 0 ? 1 : 0;
    endtask
    task automatic cyc();
        @(posedge clk);
        model();
        #1;
    endtask
    task automatic frame(input int lo, input int hi);
        vsync_n = 1'b0;
        repeat (lo) cyc();
        vsync_n = 1'b1;
        repeat (hi) cyc();
    endtask
    task automatic req(input int md);
        cif.cfg_valid = 1'b1;
        cif.cfg_mode  = 2'(md);
        cyc();
        cif.cfg_valid = 1'b0;
    endtask
    initial begin
        cur = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                cur = '{0, 0, 0, 0};
            end else begin
                chk("cfg_ready", int'(cif.cfg_ready), exp_ready);
                if (frame_tick || q.size() != 0) begin
                    chk("frame_tick", int'(frame_tick), q.size() != 0 ? 1 : 0);
                    if (q.size() != 0) cur = q.pop_front();
                end
                chk("mode", int'(mode), cur.mode);
                chk("field", int'(field), cur.field);
                chk("dither_en", int'(dither_en), cur.en);
                chk("frame_count", int'(frame_count), cur.fc);
            end
        end
    end
    initial begin
        cif.cfg_valid = 1'b0;
        cif.cfg_mode  = 2'd0;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (3) frame(8, 2092);
        req(2);
        repeat (4) frame(2, 10);
        req(3);
        repeat (13) frame(2, 6);
        vsync_n = 1'b0;
        repeat (3) cyc();
        vsync_n = 1'b1;
        req(1);
        repeat (3) cyc();
        req(0);
        repeat (2) frame(2, 6);
        repeat (260) frame(1, 3);
        req(2);
        vsync_n = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (3) cyc();
        vsync_n = 1'b1;
        repeat (4) cyc();
        for (int i = 0; i < 600; i++) begin
            vsync_n       = ($urandom_range(0, 4) != 0);
            cif.cfg_valid = ($urandom_range(0, 5) == 0);
            cif.cfg_mode  = 2'($urandom_range(0, 3));
            reset         = ($urandom_range(0, 249) == 0);
            cyc();
        end
        reset = 1'b0;
        vsync_n = 1'b1;
        cif.cfg_valid = 1'b0;
        repeat (4) cyc();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dither_ctrl.md
Name: dither_ctrl

Overview:
- Frame-synchronous controller for the 6-to-3-bit ordered dither stage in the VGA output path.
- Generates the dither field bit, a dither enable and a frame counter, all derived from vsync_n sampled on clk. No logic is clocked from vsync_n.
- Accepts dither-mode changes over a valid/ready handshake and applies them only at a frame boundary, so a mode change never tears mid-frame.

Parameters:
- FRAME_W, 8: width of frame_count.
- HOLD_FRAMES, 4: frames per field phase in mode 3. Legal range 2..255.

Ports:
- clk  input  1  system clock (25 MHz pixel clock); the only clock.
- reset  input  1  synchronous, active-high reset.
- vsync_n  input  1  active-low vertical sync from vga_sync, same clock domain.
- cfg_valid  input  1  requester has a mode-change request.
- cfg_mode  input  2  requested mode: 0 off, 1 static, 2 temporal, 3 slow temporal.
- cfg_ready  output  1  controller can accept a request.
- dither_en  output  1  1 = dither active; 0 = dither stage must pass the top bit of each channel only.
- field  output  1  dither field/phase bit to the dither stage.
- mode  output  2  currently applied mode.
- frame_count  output  FRAME_W  frames since reset, wraps.
- frame_tick  output  1  one-cycle pulse per frame boundary.

Behaviour:
- Reset (applied on a clk edge while reset=1):
  - dither_en=0, field=0, mode=0, frame_count=0, frame_tick=0, cfg_ready=1.
  - Pending request cleared, hold counter cleared, vs_q set to 1.
  - Reset overrides everything in the same cycle, including a handshake or a boundary.
- Boundary detection:
  - vs_q registers vsync_n each cycle.
  - bnd = ~vs_q & vsync_n, i.e. the rising edge of vsync_n (end of sync pulse).
  - All boundary effects are registered: if bnd is true in cycle N, the outputs change in cycle N+1.
- frame_tick=1 in cycle N+1 only.
- frame_count increments by 1 at every boundary. It wraps from 2^FRAME_W-1 to 0.
- Handshake / state machine, two states:
  - IDLE (cfg_ready=1): cfg_valid=1 captures cfg_mode into pend_mode and moves to PENDING next cycle.
  - PENDING (cfg_ready=0): cfg_valid is ignored. At the next boundary, mode<=pend_mode, the hold counter clears, field<=0, and the state returns to IDLE. cfg_ready=1 from cycle N+1.
  - Capture in the same cycle as bnd: the capture happens, and the new mode is not applied at that boundary. It applies at the following boundary.
  - cfg_ready is registered and depends only on state, never combinationally on cfg_valid.
- Per-boundary field update (applies when no mode change happens at that boundary):
  - Mode 0: field=0, dither_en=0.
  - Mode 1: field=0, dither_en=1.
  - Mode 2: field toggles at every boundary, dither_en=1.
  - Mode 3: the hold counter increments at each boundary. When it reaches HOLD_FRAMES-1 it clears and field toggles. dither_en=1.
- At a mode-change boundary:
  - field is forced to 0.
  - dither_en follows the new mode.
- Outside boundaries, all outputs hold.
- Reset mid-frame or mid-PENDING discards the pending request. After reset, the first boundary is the first rising edge of vsync_n, because vs_q=1 at reset suppresses a spurious edge.

Test Plan:
- Reset, vsync_n pulsed low for 2 lines every 525 lines over 3 frames -> frame_tick pulses exactly 3 times, each one cycle after a rising edge; frame_count=3; dither_en=0; field=0; mode=0.
- Write mode 2 (cfg_valid=1 for one cycle in IDLE) -> cfg_ready=0 next cycle; mode=2, dither_en=1, field=0 after the next boundary; field toggles 1,0,1 over the following 3 boundaries; cfg_ready=1 after the apply.
- Mode 3 with HOLD_FRAMES=4 over 12 boundaries -> field is 0 for the first 4 frames, 1 for the next 4, 0 for the next 4.
- cfg_valid asserted in the same cycle as bnd with mode 1 -> mode unchanged at that boundary, mode=1 at the next. A second cfg_valid during PENDING (mode 0) is ignored: final mode=1.
- frame_count at 255 with FRAME_W=8, one boundary -> frame_count=0 and frame_tick=1.
- reset asserted while PENDING with mode 2 and vsync_n low, released, one boundary -> mode=0, cfg_ready=1, no spurious tick at reset release, frame_count=1.
